// File: rtl/common_types_pkg.sv
// Shared types for the memory subsystem: RAM sequencing states, arbiter
// grant encoding and the common 32-bit word type.
`timescale 1ns/1ps
package common_types_pkg;

  typedef logic [31:0] word_t;
  typedef logic [3:0]  strobe_t;

  // Sequencing of the single shared RAM port.
  typedef enum logic [1:0] {
    RAM_IDLE,
    RAM_WAIT,
    RAM_DONE
  } ram_state_t;

  // Which requester owns the current RAM transaction.
  typedef enum logic {
    GRANT_I,
    GRANT_D
  } arb_grant_t;

  // Instruction fetches are always full-word reads.
  localparam strobe_t STROBE_ALL = 4'hF;

endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one RAM port between an instruction-fetch read port
// and a data read/write port. One transaction at a time, always returning
// through RAM_IDLE between transactions.
//
// Configuration macro MEM_ARBITER_RR_EN:
//   undefined - contention always goes to the data port.
//   defined   - contention alternates; the port not granted last wins.
`timescale 1ns/1ps
module mem_arbiter
  import common_types_pkg::*;
(
  input  logic        clk,
  input  logic        rst,

  // Instruction-fetch read port
  input  logic        i_req,
  input  word_t       i_addr,
  output word_t       i_rdata,
  output logic        i_done,

  // Data read/write port
  input  logic        d_req,
  input  logic        d_wen,
  input  logic [3:0]  d_strobe,
  input  word_t       d_addr,
  input  word_t       d_wdata,
  output word_t       d_rdata,
  output logic        d_done,

  // Shared RAM port
  output logic        ram_req,
  output logic        ram_wen,
  output logic [3:0]  ram_strobe,
  output word_t       ram_addr,
  output word_t       ram_wdata,
  input  word_t       ram_rdata,
  input  logic        ram_ready
);

  // FSM state and owner of the in-flight transaction. With round-robin
  // enabled, r_grant doubles as the last-grant history.
  ram_state_t r_state;
  arb_grant_t r_grant;

  // Request fields latched at grant time, held until the next grant.
  word_t      r_addr;
  strobe_t    r_strobe;
  word_t      r_wdata;

  // Registered RAM control and completion outputs.
  logic       r_ram_req;
  logic       r_ram_wen;
  logic       r_i_done;
  logic       r_d_done;

  // Single capture register shared by both read-data outputs.
  word_t      r_rdata;

  // Arbitration result, meaningful only while in RAM_IDLE.
  logic       w_any_req;
  arb_grant_t w_grant;

  // Choose the winner among the currently asserted requests.
  // NOTE: every variable written in always_comb gets a value on every path
  // (here, up-front defaults), otherwise synthesis infers a latch.
  always_comb begin
    w_any_req = i_req | d_req;
    w_grant   = GRANT_I;
    if (i_req && d_req) begin
`ifdef MEM_ARBITER_RR_EN
      w_grant = (r_grant == GRANT_D) ? GRANT_I : GRANT_D;
`else
      w_grant = GRANT_D;
`endif
    end else if (d_req) begin
      w_grant = GRANT_D;
    end
  end

  // Transaction sequencer: grant, hold RAM request until ready, pulse done.
  // NOTE: state registers use non-blocking (<=) so every flop samples the
  // pre-edge values; blocking (=) here would create order-dependent logic.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= RAM_IDLE;
      r_grant   <= GRANT_I;
      r_addr    <= '0;
      r_strobe  <= '0;
      r_wdata   <= '0;
      r_ram_req <= 1'b0;
      r_ram_wen <= 1'b0;
      r_i_done  <= 1'b0;
      r_d_done  <= 1'b0;
      r_rdata   <= '0;
    end else begin
      // Done outputs are single-cycle pulses unless re-armed below.
      r_i_done <= 1'b0;
      r_d_done <= 1'b0;

      unique case (r_state)
        RAM_IDLE: begin
          if (w_any_req) begin
            r_grant   <= w_grant;
            r_ram_req <= 1'b1;
            if (w_grant == GRANT_D) begin
              r_addr    <= d_addr;
              r_ram_wen <= d_wen;
              r_strobe  <= d_strobe;
              r_wdata   <= d_wdata;
            end else begin
              // Fetches are full-word reads; write data keeps its last value.
              r_addr    <= i_addr;
              r_ram_wen <= 1'b0;
              r_strobe  <= STROBE_ALL;
            end
            r_state <= RAM_WAIT;
          end
        end

        RAM_WAIT: begin
          // Wait indefinitely for the RAM; writes capture too (unused data).
          if (ram_ready) begin
            r_rdata   <= ram_rdata;
            r_ram_req <= 1'b0;
            r_ram_wen <= 1'b0;
            r_i_done  <= (r_grant == GRANT_I);
            r_d_done  <= (r_grant == GRANT_D);
            r_state   <= RAM_DONE;
          end
        end

        RAM_DONE: begin
          r_state <= RAM_IDLE;
        end

        default: begin
          r_state <= RAM_IDLE;
        end
      endcase
    end
  end

  // Outputs come straight from registers.
  assign ram_req    = r_ram_req;
  assign ram_wen    = r_ram_wen;
  assign ram_strobe = r_strobe;
  assign ram_addr   = r_addr;
  assign ram_wdata  = r_wdata;
  assign i_done     = r_i_done;
  assign d_done     = r_d_done;
  assign i_rdata    = r_rdata;
  assign d_rdata    = r_rdata;

endmodule
